// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Accepts a byte stream (valid/ready) of the form
//   count N (16b, MSB first), N x 16-bit words (MSB first) [, 16-bit checksum]
// and writes the words to consecutive instruction-memory addresses from 0,
// holding the core in reset until the image is complete and error-free.
//
// Optional build macro: IMEM_LOADER_CHKSUM_EN adds the trailing checksum
// field (mod-2^16 sum of all N words) and drives chk_err; without it
// chk_err is tied 0.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_data  input byte stream, in_ready registered back-pressure
//   start             pulse; restarts a load from DONE
//   wr_en/addr/data   instruction-memory write port, one strobe per word
//   core_rst          active-high core reset, released on clean completion
//   done              load finished
//   len_err, chk_err  sticky header-length / checksum errors
//
// state   | meaning
// HDR_HI  | waiting for count high byte
// HDR_LO  | waiting for count low byte
// DAT_HI  | waiting for word high byte
// DAT_LO  | waiting for word low byte
// CHK_HI  | waiting for checksum high byte (macro only)
// CHK_LO  | waiting for checksum low byte (macro only)
// DONE    | image complete, core released if no error
module imem_loader #(
    parameter int P_INST_NUM = 1024,
    parameter int P_ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    input  logic                start,
    output logic                wr_en,
    output logic [P_ADDR_W-1:0] wr_addr,
    output logic [15:0]         wr_data,
    output logic                core_rst,
    output logic                done,
    output logic                len_err,
    output logic                chk_err
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DAT_HI,
        S_DAT_LO,
`ifdef IMEM_LOADER_CHKSUM_EN
        S_CHK_HI,
        S_CHK_LO,
`endif
        S_DONE
    } state_t;

`ifdef IMEM_LOADER_CHKSUM_EN
    localparam state_t S_AFTER_DAT = S_CHK_HI;
`else
    localparam state_t S_AFTER_DAT = S_DONE;
`endif

    state_t state_q, state_d;

    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;
    logic [7:0]          hi_q, hi_d;
    logic                wr_en_q, wr_en_d;
    logic [P_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;
    logic                core_rst_q, core_rst_d;
    logic                len_err_q, len_err_d;
    logic                chk_err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic                chk_err_q;
    logic [15:0]         sum_q, sum_d;
`endif

    logic        accept;
    logic [15:0] word;
    logic [15:0] hdr_cnt;
    logic        last_word;
    logic        in_range;

    assign accept    = in_valid && in_ready_q;
    assign word      = {hi_q, in_data};
    assign hdr_cnt   = {cnt_q[15:8], in_data};
    assign last_word = ((idx_q + 16'd1) == cnt_q);
    // Words beyond the memory depth are still consumed, just never written.
    assign in_range  = ({16'd0, idx_q} < 32'(P_INST_NUM));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HDR_HI;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI: if (accept) state_d = S_HDR_LO;
            S_HDR_LO: if (accept) state_d = (hdr_cnt != 16'd0) ? S_DAT_HI : S_AFTER_DAT;
            S_DAT_HI: if (accept) state_d = S_DAT_LO;
            S_DAT_LO: if (accept) state_d = last_word ? S_AFTER_DAT : S_DAT_HI;
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK_HI: if (accept) state_d = S_CHK_LO;
            S_CHK_LO: if (accept) state_d = S_DONE;
`endif
            S_DONE:   if (start)  state_d = S_HDR_HI;
            default:  state_d = S_HDR_HI;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        len_err_d = len_err_q;
        chk_err_d = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_err_d = chk_err_q;
        sum_d     = sum_q;
`endif
        case (state_q)
            S_HDR_HI: if (accept) cnt_d[15:8] = in_data;
            S_HDR_LO: if (accept) begin
                cnt_d[7:0] = in_data;
                idx_d      = 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
                sum_d      = 16'd0;
`endif
                if ({16'd0, hdr_cnt} > 32'(P_INST_NUM)) len_err_d = 1'b1;
            end
            S_DAT_HI: if (accept) hi_d = in_data;
            S_DAT_LO: if (accept) begin
                if (in_range) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[P_ADDR_W-1:0];
                    wr_data_d = word;
                end
                idx_d = idx_q + 16'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                sum_d = sum_q + word;
`endif
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK_HI: if (accept) hi_d = in_data;
            S_CHK_LO: if (accept && (word != sum_q)) chk_err_d = 1'b1;
`endif
            S_DONE: if (start) begin
                len_err_d = 1'b0;
                chk_err_d = 1'b0;
            end
            default: ;
        endcase
        in_ready_d = (state_d != S_DONE);
        // When the last accept also writes, completion is reported one
        // cycle later so the core never leaves reset before the final write.
        done_d     = (state_d == S_DONE) && !wr_en_d;
        core_rst_d = !(done_d && !len_err_d && !chk_err_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            hi_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
            len_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_err_q  <= 1'b0;
            sum_q      <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
            len_err_q  <= len_err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_err_q  <= chk_err_d;
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign core_rst = core_rst_q;
    assign len_err  = len_err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
    assign chk_err  = chk_err_q;
`else
    assign chk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (small instance: 4-word memory).
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [15:0] wr_data;
    logic       core_rst;
    logic       done;
    logic       len_err;
    logic       chk_err;

    imem_loader #(.P_INST_NUM(4), .P_ADDR_W(2)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .core_rst (core_rst),
        .done     (done),
        .len_err  (len_err),
        .chk_err  (chk_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int wr_snap;

    logic        cap_we;
    logic [1:0]  cap_addr;
    logic [15:0] cap_data;
    logic [15:0] last_sum;

    always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte offered for one edge, then 'gap' idle cycles; write port
    // state right after the accepting edge is captured.
    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        cyc();
        cap_we   = wr_en;
        cap_addr = wr_addr;
        cap_data = wr_data;
        in_valid = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic send_word(input string tag, input logic [15:0] w, input int gap,
                             input logic exp_we, input logic [1:0] exp_addr);
        send(w[15:8], gap);
        send(w[7:0], gap);
        check({tag, "_we"}, cap_we, exp_we);
        if (exp_we) begin
            check({tag, "_addr"}, cap_addr, exp_addr);
            check({tag, "_data"}, cap_data, w);
        end
    endtask

    task automatic send_chk(input logic [15:0] s);
        last_sum = s;
`ifdef IMEM_LOADER_CHKSUM_EN
        send(last_sum[15:8], 0);
        send(last_sum[7:0], 0);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        repeat (2) cyc();
        check("rst_wr_en",    wr_en, 1'b0);
        check("rst_wr_addr",  wr_addr, 2'd0);
        check("rst_wr_data",  wr_data, 16'h0000);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_done",     done, 1'b0);
        check("rst_len_err",  len_err, 1'b0);
        check("rst_chk_err",  chk_err, 1'b0);
        rst_n = 1'b1;
        cyc();
        check("rst_in_ready", in_ready, 1'b1);

        // Load N=3, valid held high
        send(8'h00, 0); send(8'h03, 0);
        send_word("t1w0", 16'h1234, 0, 1'b1, 2'd0);
        send_word("t1w1", 16'hABCD, 0, 1'b1, 2'd1);
        send_word("t1w2", 16'h0001, 0, 1'b1, 2'd2);
`ifndef IMEM_LOADER_CHKSUM_EN
        check("t1_done_late", done, 1'b0);
        check("t1_ready_off", in_ready, 1'b0);
`endif
        send_chk(16'hBE02);
        cyc();
        check("t1_done",     done, 1'b1);
        check("t1_core_rst", core_rst, 1'b0);
        check("t1_in_ready", in_ready, 1'b0);
        check("t1_wr_idle",  wr_en, 1'b0);
        check("t1_addr_hold", wr_addr, 2'd2);
        check("t1_data_hold", wr_data, 16'h0001);

        // Same stream with bubbles between bytes
        pulse_start();
        check("t2_done_clr", done, 1'b0);
        check("t2_core_rst", core_rst, 1'b1);
        check("t2_in_ready", in_ready, 1'b1);
        wr_snap = wr_cnt;
        send(8'h00, 1); send(8'h03, 1);
        send_word("t2w0", 16'h1234, 1, 1'b1, 2'd0);
        send_word("t2w1", 16'hABCD, 1, 1'b1, 2'd1);
        send_word("t2w2", 16'h0001, 1, 1'b1, 2'd2);
        send_chk(16'hBE02);
        cyc();
        check("t2_wr_count", wr_cnt - wr_snap, 3);
        check("t2_done",     done, 1'b1);
        check("t2_core_rst_rel", core_rst, 1'b0);

        // N=0: straight to completion, no writes
        pulse_start();
        wr_snap = wr_cnt;
        send(8'h00, 0); send(8'h00, 0);
        send_chk(16'h0000);
        check("t3_done",     done, 1'b1);
        check("t3_core_rst", core_rst, 1'b0);
        check("t3_in_ready", in_ready, 1'b0);
        cyc();
        check("t3_no_write", wr_cnt - wr_snap, 0);

        // N=6 into a 4-word memory
        pulse_start();
        send(8'h00, 0); send(8'h06, 0);
        check("t4_len_err", len_err, 1'b1);
        send_word("t4w0", 16'h0100, 0, 1'b1, 2'd0);
        send_word("t4w1", 16'h0101, 0, 1'b1, 2'd1);
        send_word("t4w2", 16'h0102, 0, 1'b1, 2'd2);
        send_word("t4w3", 16'h0103, 0, 1'b1, 2'd3);
        send_word("t4w4", 16'h0104, 0, 1'b0, 2'd0);
        send_word("t4w5", 16'h0105, 0, 1'b0, 2'd0);
        send_chk(16'h060F);
        cyc();
        check("t4_done",      done, 1'b1);
        check("t4_core_rst",  core_rst, 1'b1);
        check("t4_len_sticky", len_err, 1'b1);
        check("t4_addr_hold", wr_addr, 2'd3);
        check("t4_data_hold", wr_data, 16'h0103);

        // Abort mid-load with rst_n, then reload and restart
        pulse_start();
        check("t5_len_clr", len_err, 1'b0);
        send(8'h00, 0); send(8'h04, 0);
        send_word("t5w0", 16'h1111, 0, 1'b1, 2'd0);
        send_word("t5w1", 16'h2222, 0, 1'b1, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_we",   wr_en, 1'b0);
        check("t5_async_addr", wr_addr, 2'd0);
        check("t5_async_data", wr_data, 16'h0000);
        check("t5_async_crst", core_rst, 1'b1);
        check("t5_async_rdy",  in_ready, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t5_ready_back", in_ready, 1'b1);
        send(8'h00, 0); send(8'h02, 0);
        send_word("t5r0", 16'h5A5A, 0, 1'b1, 2'd0);
        send_word("t5r1", 16'hC3C3, 0, 1'b1, 2'd1);
        send_chk(16'h1E1D);
        cyc();
        check("t5_done1", done, 1'b1);
        check("t5_crst1", core_rst, 1'b0);
        pulse_start();
        check("t5_done0", done, 1'b0);
        send(8'h00, 0); send(8'h01, 0);
        send_word("t5s0", 16'h0F0F, 0, 1'b1, 2'd0);
        send_chk(16'h0F0F);
        cyc();
        check("t5_done2", done, 1'b1);
        check("t5_crst2", core_rst, 1'b0);

`ifdef IMEM_LOADER_CHKSUM_EN
        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        send_word("t6w0", 16'h8000, 0, 1'b1, 2'd0);
        send_word("t6w1", 16'h8001, 0, 1'b1, 2'd1);
        send_chk(16'h0001);
        cyc();
        check("t6_ok_done", done, 1'b1);
        check("t6_ok_crst", core_rst, 1'b0);
        check("t6_ok_chk",  chk_err, 1'b0);
        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        send_word("t7w0", 16'h8000, 0, 1'b1, 2'd0);
        send_word("t7w1", 16'h8001, 0, 1'b1, 2'd1);
        send_chk(16'h0002);
        cyc();
        check("t7_bad_done", done, 1'b1);
        check("t7_bad_crst", core_rst, 1'b1);
        check("t7_bad_chk",  chk_err, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction-memory loader that sits directly upstream of the processor core and its instruction memory.
- Receives a byte stream over a valid/ready handshake from a UART/debug bridge, assembles 16-bit instruction words, and writes them to consecutive instruction-memory addresses from 0.
- Holds the core in reset until the image is complete, replacing the static file-based preload for hardware bring-up.

Parameters:
- P_INST_NUM, 1024: instruction memory depth in words.
- P_ADDR_W, 10: write address width; must satisfy 2^P_ADDR_W >= P_INST_NUM.

Ports:
- clk  input  1: global clock.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: input byte valid.
- in_data  input  8: input byte.
- in_ready  output  1: loader can accept a byte.
- start  input  1: single-cycle pulse; restarts a load from DONE.
- wr_en  output  1: instruction-memory write strobe, one cycle per word.
- wr_addr  output  P_ADDR_W: word address.
- wr_data  output  16: instruction word.
- core_rst  output  1: active-high reset to the core.
- done  output  1: load finished.
- len_err  output  1: sticky; header word count exceeded P_INST_NUM.
- chk_err  output  1: sticky checksum mismatch (tied 0 without the macro).

Behaviour:
- Byte transfer: a byte is accepted on a clock edge where in_valid && in_ready.
- Stream format, all fields high byte first:
  - count N (16 bits);
  - N words;
  - [checksum, only when the macro is defined].
- FSM states: HDR_HI, HDR_LO, DAT_HI, DAT_LO, [CHK_HI, CHK_LO], DONE.
- Reset (async, rst_n=0):
  - state=HDR_HI, wr_en=0, wr_addr=0, wr_data=0;
  - core_rst=1, done=0, len_err=0, chk_err=0;
  - in_ready=1 one cycle after rst_n deasserts.
- in_ready = 1 in every state except DONE. Registered; no combinational path from in_valid.
- HDR_HI -> HDR_LO on accept: latch N[15:8].
- HDR_LO on accept: latch N[7:0], clear the word counter.
  - If N > P_INST_NUM: set len_err.
  - Next state is DAT_HI if N != 0.
  - If N == 0: next state is CHK_HI (macro) or DONE.
- DAT_HI -> DAT_LO on accept: latch the high byte.
- DAT_LO on accept:
  - If word index < P_INST_NUM: the next cycle has wr_en=1, wr_addr=index, wr_data={hi,lo}. Latency is exactly 1 cycle after the low-byte accept.
  - Otherwise: the word is consumed and discarded (no write).
  - Increment the index. Go to DAT_HI, or to CHK_HI/DONE when index+1 == N.
- Write port:
  - wr_en is high for exactly one cycle per written word.
  - wr_addr/wr_data are held between writes.
  - Memory accepts a write every cycle; there is no write back-pressure.
- Word index is 16 bits; addresses wrap never, because writes are gated by index < P_INST_NUM.
- Bubbles: in_valid low in any state causes no state change, and a partial word is retained.
- DONE:
  - done=1, in_ready=0;
  - core_rst=0 only if len_err=0 and chk_err=0, otherwise core_rst stays 1;
  - done and core_rst update in the cycle after the final accept, or after the final write when one occurs.
- start in DONE: next cycle state=HDR_HI, core_rst=1, done=0, len_err=0, chk_err=0.
- start outside DONE is ignored.
- rst_n asserted mid-load: immediate abort to reset values. Already-written memory contents are not cleared.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- Defined:
  - after the data words, two extra bytes carry a 16-bit checksum (CHK_HI, CHK_LO);
  - expected value = modulo-2^16 sum of all N received words, including discarded ones;
  - on mismatch at the CHK_LO accept, chk_err=1 (sticky), DONE is entered, and core_rst stays 1.
- Undefined:
  - CHK states are absent and data goes directly to DONE;
  - chk_err is constant 0.

Test Plan:
- Load N=3, words 0x1234,0xABCD,0x0001, in_valid held high:
  - writes to addresses 0,1,2 with those values, one cycle after each low byte;
  - done=1 and core_rst=0 after the last write, then in_ready=0.
- Same stream with in_valid toggling every other cycle: identical writes and final state; no duplicate or missed wr_en.
- N=0:
  - no writes;
  - DONE reached one cycle after the second header byte (macro off), core_rst=0.
- P_INST_NUM=4, N=6:
  - len_err=1 after the header;
  - only addresses 0-3 written, 6 words consumed;
  - DONE with core_rst=1.
- rst_n pulled low after 2 of 4 words, then a full N=2 load followed by start and a second N=1 load:
  - async return to reset values;
  - the reload writes addresses 0-1, then restarts and writes address 0;
  - done toggles 1->0->1.
- Macro on, N=2, words 0x8000,0x8001:
  - checksum 0x0001 -> core_rst=0;
  - checksum 0x0002 -> chk_err=1 and core_rst=1.
